// File: rtl/tl_sensor_cond.sv
// tl_sensor_cond: conditions the two raw car-detector inputs (streets A and B)
// into clean traffic-present flags Ta/Tb for the traffic light controller.
// Each channel: 2-flop synchronizer -> debounce/hold FSM -> registered T.
// Optional macro TL_SENSOR_STUCK_EN adds a per-channel run counter and a
// STUCK state that drops T and raises stuck_* after STUCK_CYCLES of
// continuous occupancy.
module tl_sensor_cond #(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned HOLD_CYCLES  = 8,
  parameter int unsigned STUCK_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic sa_raw,
  input  logic sb_raw,
  output logic Ta,
  output logic Tb,
  output logic stuck_a,
  output logic stuck_b
);

  localparam int unsigned MAX_CYCLES = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES) + 1;
  localparam int unsigned NCH        = 2;

  // Elaboration-time sanity checks on the configuration
  if (DEB_CYCLES < 2) begin : g_bad_deb
    $error("tl_sensor_cond: DEB_CYCLES must be >= 2");
  end
  if (HOLD_CYCLES < 2) begin : g_bad_hold
    $error("tl_sensor_cond: HOLD_CYCLES must be >= 2");
  end
  if (STUCK_CYCLES < 2) begin : g_bad_stuck
    $error("tl_sensor_cond: STUCK_CYCLES must be >= 2");
  end

`ifdef TL_SENSOR_STUCK_EN
  localparam int unsigned RW = $clog2(STUCK_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_EMPTY    = 3'd0,
    ST_CONFIRM  = 3'd1,
    ST_OCCUPIED = 3'd2,
    ST_HOLD     = 3'd3,
    ST_STUCK    = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_EMPTY    = 3'd0,
    ST_CONFIRM  = 3'd1,
    ST_OCCUPIED = 3'd2,
    ST_HOLD     = 3'd3
  } state_e;
`endif

  logic [NCH-1:0] raw_c;
  assign raw_c = {sb_raw, sa_raw};

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic          sync1_q;
    logic          sync2_q;
    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          t_q;
    logic          busy_c;
    logic          s_c;

    assign s_c    = sync2_q;
    assign busy_c = (state_q == ST_OCCUPIED) || (state_q == ST_HOLD);

    // Two-flop synchronizer for the asynchronous detector input
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= raw_c[ch];
        sync2_q <= sync1_q;
      end
    end

`ifdef TL_SENSOR_STUCK_EN
    logic [RW-1:0] run_q;
    logic [RW-1:0] run_d;
    logic          stuck_q;

    // Saturating occupancy run counter; cleared whenever the street is not busy
    always_comb begin
      run_d = '0;
      if (busy_c) begin
        run_d = (run_q == RW'(STUCK_CYCLES)) ? run_q : run_q + RW'(1);
      end
    end
`endif

    // Debounce / hold next-state logic; counter is reloaded on every entry
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        ST_EMPTY: begin
          if (s_c) begin
            state_d = ST_CONFIRM;
            cnt_d   = CW'(1);
          end
        end
        ST_CONFIRM: begin
          if (!s_c) begin
            state_d = ST_EMPTY;
            cnt_d   = '0;
          end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            state_d = ST_OCCUPIED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_OCCUPIED: begin
          if (!s_c) begin
            state_d = ST_HOLD;
            cnt_d   = CW'(1);
          end
        end
        ST_HOLD: begin
          if (s_c) begin
            state_d = ST_OCCUPIED;
            cnt_d   = '0;
          end else if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
            state_d = ST_EMPTY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef TL_SENSOR_STUCK_EN
        ST_STUCK: begin
          cnt_d = '0;
          if (!s_c) begin
            state_d = ST_EMPTY;
          end
        end
`endif
        default: begin
          state_d = ST_EMPTY;
          cnt_d   = '0;
        end
      endcase
`ifdef TL_SENSOR_STUCK_EN
      // A street busy for STUCK_CYCLES is treated as a failed sensor
      if (busy_c && (run_q == RW'(STUCK_CYCLES - 1))) begin
        state_d = ST_STUCK;
        cnt_d   = '0;
      end
`endif
    end

    // State, counter and registered T decode of the next state
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= ST_EMPTY;
        cnt_q   <= '0;
        t_q     <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        t_q     <= (state_d == ST_OCCUPIED) || (state_d == ST_HOLD);
      end
    end

`ifdef TL_SENSOR_STUCK_EN
    // Run counter and registered stuck flag
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        run_q   <= '0;
        stuck_q <= 1'b0;
      end else begin
        run_q   <= run_d;
        stuck_q <= (state_d == ST_STUCK);
      end
    end
`endif
  end

  assign Ta = g_ch[0].t_q;
  assign Tb = g_ch[1].t_q;

`ifdef TL_SENSOR_STUCK_EN
  assign stuck_a = g_ch[0].stuck_q;
  assign stuck_b = g_ch[1].stuck_q;
`else
  assign stuck_a = 1'b0;
  assign stuck_b = 1'b0;
`endif

endmodule

// File: tb/tb_tl_sensor_cond.sv
// Testbench for tl_sensor_cond: scoreboard of expected {stuck_b,stuck_a,Tb,Ta}
// per clock, pushed as stimulus is planned and popped after each edge.
module tb_tl_sensor_cond;

  logic clk;
  logic reset;
  logic sa_raw;
  logic sb_raw;
  logic Ta;
  logic Tb;
  logic stuck_a;
  logic stuck_b;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  logic [3:0] exp_v;
  logic [3:0] got_v;

  tl_sensor_cond #(
    .DEB_CYCLES  (4),
    .HOLD_CYCLES (8),
    .STUCK_CYCLES(32)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sa_raw (sa_raw),
    .sb_raw (sb_raw),
    .Ta     (Ta),
    .Tb     (Tb),
    .stuck_a(stuck_a),
    .stuck_b(stuck_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clear everything between scenarios, releasing between edges
  task automatic pulse_reset();
    sa_raw = 1'b0;
    sb_raw = 1'b0;
    reset  = 1'b1;
    #2;
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    sa_raw = 1'b0;
    sb_raw = 1'b0;
    #1;
    got_v = {stuck_b, stuck_a, Tb, Ta};
    checks++;
    if (got_v !== 4'b0000) begin
      errors++;
      $display("FAIL reset_initial got %b exp 0000", got_v);
    end
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) exp_q.push_back(4'b0000);
    for (int i = 1; i <= 4; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      got_v = {stuck_b, stuck_a, Tb, Ta};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL reset_idle tick %0d got %b exp %b", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_arrival();
    pulse_reset();
    sa_raw = 1'b1;
    for (int i = 1; i <= 9; i++) exp_q.push_back({3'b000, (i >= 6)});
    for (int i = 1; i <= 9; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      got_v = {stuck_b, stuck_a, Tb, Ta};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL arrival tick %0d got %b exp %b", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_glitch();
    pulse_reset();
    for (int i = 1; i <= 12; i++) exp_q.push_back(4'b0000);
    sa_raw = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      if (i == 4) sa_raw = 1'b0;
      tick();
      exp_v = exp_q.pop_front();
      got_v = {stuck_b, stuck_a, Tb, Ta};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL glitch tick %0d got %b exp %b", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_gap();
    pulse_reset();
    sa_raw = 1'b1;
    for (int i = 1; i <= 7; i++) tick();
    // Low for 5 samples, then high again: Ta must bridge the gap
    for (int i = 1; i <= 10; i++) exp_q.push_back(4'b0001);
    sa_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 6) sa_raw = 1'b1;
      tick();
      exp_v = exp_q.pop_front();
      got_v = {stuck_b, stuck_a, Tb, Ta};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL gap_bridge tick %0d got %b exp %b", i, got_v, exp_v);
      end
    end
    // Held low: Ta still 1 after edge m+8, 0 after edge m+9
    for (int i = 1; i <= 12; i++) exp_q.push_back({3'b000, (i <= 9)});
    sa_raw = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      got_v = {stuck_b, stuck_a, Tb, Ta};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL gap_release tick %0d got %b exp %b", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_simultaneous();
    pulse_reset();
    for (int i = 1; i <= 8; i++) exp_q.push_back({2'b00, (i >= 6), (i >= 6)});
    sa_raw = 1'b1;
    sb_raw = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      got_v = {stuck_b, stuck_a, Tb, Ta};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL simul_rise tick %0d got %b exp %b", i, got_v, exp_v);
      end
    end
    // Release B only; A must not move
    for (int i = 1; i <= 10; i++) exp_q.push_back({2'b00, (i <= 9), 1'b1});
    sb_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      got_v = {stuck_b, stuck_a, Tb, Ta};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL simul_b_fall tick %0d got %b exp %b", i, got_v, exp_v);
      end
    end
    // 3-sample glitch on B only
    for (int i = 1; i <= 11; i++) exp_q.push_back(4'b0001);
    sb_raw = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      if (i == 4) sb_raw = 1'b0;
      tick();
      exp_v = exp_q.pop_front();
      got_v = {stuck_b, stuck_a, Tb, Ta};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL simul_b_glitch tick %0d got %b exp %b", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_stuck();
    pulse_reset();
    sa_raw = 1'b1;
`ifdef TL_SENSOR_STUCK_EN
    for (int i = 1; i <= 42; i++)
      exp_q.push_back({2'b00, (i >= 38), (i >= 6) && (i < 38)});
`else
    for (int i = 1; i <= 42; i++) exp_q.push_back({3'b000, (i >= 6)});
`endif
    for (int i = 1; i <= 42; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      got_v = {stuck_b, stuck_a, Tb, Ta};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL stuck_hold tick %0d got %b exp %b", i, got_v, exp_v);
      end
    end
    sa_raw = 1'b0;
`ifdef TL_SENSOR_STUCK_EN
    for (int i = 1; i <= 6; i++) exp_q.push_back({2'b00, (i <= 2), 1'b0});
`else
    for (int i = 1; i <= 6; i++) exp_q.push_back(4'b0001);
`endif
    for (int i = 1; i <= 6; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      got_v = {stuck_b, stuck_a, Tb, Ta};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL stuck_release tick %0d got %b exp %b", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    pulse_reset();
    sa_raw = 1'b1;
    for (int i = 1; i <= 6; i++) tick();
    got_v = {stuck_b, stuck_a, Tb, Ta};
    checks++;
    if (got_v !== 4'b0001) begin
      errors++;
      $display("FAIL async_pre got %b exp 0001", got_v);
    end
    // Raise reset between edges: outputs must clear without a clock
    #2;
    reset = 1'b1;
    #1;
    got_v = {stuck_b, stuck_a, Tb, Ta};
    checks++;
    if (got_v !== 4'b0000) begin
      errors++;
      $display("FAIL async_clear got %b exp 0000", got_v);
    end
    #1;
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) exp_q.push_back({3'b000, (i >= 6)});
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      got_v = {stuck_b, stuck_a, Tb, Ta};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL async_rearm tick %0d got %b exp %b", i, got_v, exp_v);
      end
    end
    // Reset mid-CONFIRM then re-arrival from scratch
    pulse_reset();
    sa_raw = 1'b1;
    for (int i = 1; i <= 4; i++) tick();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) exp_q.push_back({3'b000, (i >= 6)});
    for (int i = 1; i <= 7; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      got_v = {stuck_b, stuck_a, Tb, Ta};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL confirm_reset tick %0d got %b exp %b", i, got_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arrival();
    test_glitch();
    test_gap();
    test_simultaneous();
    test_stuck();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tl_sensor_cond.md
Name: tl_sensor_cond

Overview:
- Upstream conditioner for the traffic light controller. Turns the two raw, noisy car-detector inputs (street A and street B) into the clean traffic-present signals Ta and Tb that the controller consumes.
- Each channel has three stages:
  - 2-flop synchronizer.
  - Debounce stage: a rising detection must be stable before it is accepted.
  - Hold stage: bridges short gaps between cars so Ta/Tb do not chatter.
- Channels A and B are identical and fully independent.

Parameters:
- DEB_CYCLES, 4, consecutive synchronized-high samples needed to assert T (legal range ≥2).
- HOLD_CYCLES, 8, consecutive synchronized-low samples needed to deassert T (legal range ≥2).
- STUCK_CYCLES, 1024, consecutive asserted-T cycles after which a channel is declared stuck (used only with TL_SENSOR_STUCK_EN).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- sa_raw  input  1  raw detector, street A; asynchronous to clk.
- sb_raw  input  1  raw detector, street B; asynchronous to clk.
- Ta  output  1  traffic present on street A (registered).
- Tb  output  1  traffic present on street B (registered).
- stuck_a  output  1  street A sensor stuck flag (registered).
- stuck_b  output  1  street B sensor stuck flag (registered).

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high: reset=1 immediately clears, with no clock edge, all sync flops, all counters, Ta, Tb, stuck_a and stuck_b, and puts both FSMs in EMPTY.
- Synchronizer: s = second flop of a 2-flop chain on the raw input.
- Per-channel FSM with a counter cnt (width = $clog2 of the larger of DEB_CYCLES and HOLD_CYCLES, plus 1):
  - EMPTY (T=0):
    - s=1 → CONFIRM, cnt=1.
  - CONFIRM (T=0):
    - s=0 → EMPTY.
    - s=1 and cnt==DEB_CYCLES-1 → OCCUPIED.
    - otherwise cnt++.
  - OCCUPIED (T=1):
    - s=0 → HOLD, cnt=1.
  - HOLD (T=1):
    - s=1 → OCCUPIED.
    - s=0 and cnt==HOLD_CYCLES-1 → EMPTY.
    - otherwise cnt++.
- T is a registered decode of state: 1 in OCCUPIED and HOLD, 0 otherwise.
- Latency:
  - Raw first sampled high at edge j and held → T=1 after edge j+DEB_CYCLES+1.
  - Raw first sampled low at edge m and held → T=0 after edge m+HOLD_CYCLES+1.
- Boundary conditions:
  - A high pulse shorter than DEB_CYCLES samples never asserts T.
  - A low gap shorter than HOLD_CYCLES samples never deasserts T.
  - Counters never wrap; they are reloaded on every state entry.
  - Simultaneous events on A and B are processed independently in the same cycle.
  - Reset asserted mid-CONFIRM or mid-HOLD drops everything to 0 at once.
  - After reset deasserts, the first transition is evaluated on the next edge.
- stuck_a and stuck_b are tied 0 unless the optional feature is compiled in.

Optional Feature:
- Macro: TL_SENSOR_STUCK_EN.
- When defined:
  - Each channel has a saturating run counter. It increments every cycle the FSM is in OCCUPIED or HOLD, and clears in any other state.
  - When the counter reaches STUCK_CYCLES, the FSM enters a fifth state, STUCK: T=0 and stuck=1. This prevents a failed sensor from starving the other street.
  - STUCK exits to EMPTY only when s=0 is sampled; stuck clears on that same edge.
  - Reset clears STUCK.
- When undefined:
  - No run counter and no STUCK state.
  - stuck_a and stuck_b are constant 0.
  - T may remain 1 indefinitely.

Test Plan:
- Async reset: drive sa_raw=1 until Ta=1, then raise reset between clock edges → Ta, Tb, stuck_a, stuck_b all 0 before the next edge. Release reset with sa_raw still 1 → Ta=1 again after edge j+5 (DEB_CYCLES=4).
- Clean arrival: sa_raw rises before edge j and is held → Ta=0 after edge j+4, Ta=1 after edge j+5. Tb stays 0 throughout.
- Glitch reject: sa_raw high for exactly 3 edges, then low → Ta never asserts; FSM returns to EMPTY.
- Gap bridging (HOLD_CYCLES=8): with Ta=1, drop sa_raw for 5 edges, then raise it → Ta stays 1. Drop it again and hold low from edge m → Ta=1 after edge m+8, Ta=0 after edge m+9.
- Simultaneous: sa_raw and sb_raw rise before the same edge j → Ta and Tb both rise after edge j+5. Later, glitch sb_raw only → Ta is unaffected.
- Stuck (TL_SENSOR_STUCK_EN, STUCK_CYCLES=32): hold sa_raw=1 → Ta is high for exactly 32 cycles, then Ta=0 and stuck_a=1. Release sa_raw at edge m → stuck_a=0 after edge m+2. Rebuild without the macro → Ta stays 1 and stuck_a=0.
